// File: rtl/dma_rd_arbiter_pkg.sv
// Shared types and constants for the DMA read arbiter: FSM encoding,
// default field widths and the full-burst length helper.
package dma_rd_arbiter_pkg;

   typedef enum logic [0:0] {
      ST_ARB   = 1'b0,
      ST_BURST = 1'b1
   } state_e;

   localparam int DEF_LEN_W = 8;
   localparam int DEF_CNT_W = 16;

   // Longest burst encodable in a w-bit length field (all ones).
   function automatic logic [31:0] len_all_ones(input int w);
      return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
   endfunction

endpackage

// File: rtl/dma_rd_arbiter_rr.sv
// Combinational round-robin priority encoder: the search starts one past
// the last granted requester and wraps modulo N_REQ.
module rr_arbiter
   import dma_rd_arbiter_pkg::*;
#(
   parameter int N_REQ = 2,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] last_grant,
   output logic [IDX_W-1:0] grant,
   output logic             any_valid
);

   int idx;

   always_comb begin
      grant     = '0;
      any_valid = 1'b0;
      idx       = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(last_grant) + k) % N_REQ;
         if (!any_valid && req[idx]) begin
            grant     = IDX_W'(idx);
            any_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dma_rd_arbiter.sv
// Round-robin arbiter granting whole read bursts from N_REQ requesters to a
// single DMA read engine, with per-requester frame-repeat transfer counters.
module dma_rd_arbiter
   import dma_rd_arbiter_pkg::*;
#(
   parameter int N_REQ  = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 256,
   parameter int LEN_W  = DEF_LEN_W,
   parameter int CNT_W  = DEF_CNT_W,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clear,
   input  logic                      run,
   input  logic                      cfg_valid,
   input  logic [IDX_W-1:0]          cfg_sel,
   input  logic [CNT_W-1:0]          cfg_len,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr,
   output logic [N_REQ*DATA_W-1:0]   req_rdata,
   output logic [N_REQ-1:0]          req_ready,
   output logic                      dma_valid,
   output logic [ADDR_W-1:0]         dma_addr,
   output logic [LEN_W-1:0]          dma_len,
   input  logic [DATA_W-1:0]         dma_rdata,
   input  logic                      dma_ready,
   output logic                      busy
);

   state_e                 state_q, state_d;
   logic [IDX_W-1:0]       g_q, g_d;
   logic [IDX_W-1:0]       last_q, last_d;
   logic [LEN_W-1:0]       beat_q, beat_d;
   logic [LEN_W-1:0]       len_q, len_d;
   logic [CNT_W-1:0]       cfg_q [N_REQ];
   logic [CNT_W-1:0]       cfg_d [N_REQ];
   logic [CNT_W-1:0]       shadow_q [N_REQ];
   logic [CNT_W-1:0]       shadow_d [N_REQ];
   logic [CNT_W-1:0]       rem_q [N_REQ];
   logic [CNT_W-1:0]       rem_d [N_REQ];

   logic [IDX_W-1:0]       grant;
   logic                   any_valid;
   logic [CNT_W-1:0]       grant_rem;
   logic                   beat_fire;
   logic                   last_beat;

   rr_arbiter #(.N_REQ(N_REQ)) u_rr (
      .req        (req_valid),
      .last_grant (last_q),
      .grant      (grant),
      .any_valid  (any_valid)
   );

   assign grant_rem = rem_q[grant];
   // A beat is a completed handshake; the grant stays locked while stalled.
   assign beat_fire = (state_q == ST_BURST) && req_valid[g_q] && dma_ready;
   assign last_beat = beat_fire && (beat_q == len_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_ARB;
         g_q      <= '0;
         last_q   <= IDX_W'(N_REQ - 1);
         beat_q   <= '0;
         len_q    <= '0;
         cfg_q    <= '{default: '0};
         shadow_q <= '{default: '0};
         rem_q    <= '{default: '0};
      end else begin
         state_q  <= state_d;
         g_q      <= g_d;
         last_q   <= last_d;
         beat_q   <= beat_d;
         len_q    <= len_d;
         cfg_q    <= cfg_d;
         shadow_q <= shadow_d;
         rem_q    <= rem_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_ARB:   if (any_valid) state_d = ST_BURST;
         ST_BURST: if (last_beat) state_d = ST_ARB;
         default:  state_d = ST_ARB;
      endcase
   end

   always_comb begin
      g_d      = g_q;
      last_d   = last_q;
      beat_d   = beat_q;
      len_d    = len_q;
      cfg_d    = cfg_q;
      shadow_d = shadow_q;
      rem_d    = rem_q;

      if (state_q == ST_ARB && any_valid) begin
         g_d    = grant;
         beat_d = '0;
         len_d  = (|grant_rem[CNT_W-1:LEN_W]) ? LEN_W'(len_all_ones(LEN_W))
                                              : grant_rem[LEN_W-1:0];
      end

      if (beat_fire) begin
         beat_d = beat_q + LEN_W'(1);
         if (last_beat) last_d = g_q;
         rem_d[g_q] = (rem_q[g_q] == '0) ? shadow_q[g_q] : rem_q[g_q] - CNT_W'(1);
      end

      if (clear) begin
         cfg_d = '{default: '0};
      end else if (cfg_valid && (int'(cfg_sel) < N_REQ)) begin
         cfg_d[cfg_sel] = cfg_len;
      end

      // run overrides the decrement above; the latched len_q is untouched.
      if (run) begin
         shadow_d = cfg_q;
         rem_d    = cfg_q;
      end
   end

   always_comb begin
      busy      = 1'b0;
      dma_valid = 1'b0;
      dma_addr  = '0;
      req_ready = '0;
      if (state_q == ST_BURST) begin
         busy           = 1'b1;
         dma_valid      = req_valid[g_q];
         dma_addr       = req_addr[int'(g_q)*ADDR_W +: ADDR_W];
         req_ready[g_q] = dma_ready;
      end
   end

   assign dma_len   = len_q;
   assign req_rdata = {N_REQ{dma_rdata}};

endmodule

// File: tb/tb_dma_rd_arbiter.sv
// Directed bench for dma_rd_arbiter: burst lengths, round-robin order,
// stall behaviour, mid-burst reset and mid-burst run.
module tb_dma_rd_arbiter;

   localparam int N  = 2;
   localparam int AW = 32;
   localparam int DW = 256;
   localparam int LW = 8;
   localparam int CW = 16;
   localparam logic [AW-1:0] ADDR0 = 32'h1000_0040;
   localparam logic [AW-1:0] ADDR1 = 32'h2000_0080;

   logic            clk = 1'b0;
   logic            rst, clear, run, cfg_valid, dma_ready;
   logic [0:0]      cfg_sel;
   logic [CW-1:0]   cfg_len;
   logic [N-1:0]    req_valid;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_rdata;
   logic [N-1:0]    req_ready;
   logic            dma_valid, busy;
   logic [AW-1:0]   dma_addr;
   logic [LW-1:0]   dma_len;
   logic [DW-1:0]   dma_rdata;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   dma_rd_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .clear(clear), .run(run), .cfg_valid(cfg_valid),
      .cfg_sel(cfg_sel), .cfg_len(cfg_len), .req_valid(req_valid), .req_addr(req_addr),
      .req_rdata(req_rdata), .req_ready(req_ready), .dma_valid(dma_valid),
      .dma_addr(dma_addr), .dma_len(dma_len), .dma_rdata(dma_rdata),
      .dma_ready(dma_ready), .busy(busy)
   );

   // Drivers: all start and end on a falling edge.
   task automatic do_reset();
      rst = 1'b1; clear = 1'b0; run = 1'b0; cfg_valid = 1'b0; cfg_sel = '0;
      cfg_len = '0; req_valid = '0; dma_ready = 1'b1; dma_rdata = '0;
      req_addr = {ADDR1, ADDR0};
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic cfg_write(input int sel, input int len);
      cfg_valid = 1'b1; cfg_sel = 1'(sel); cfg_len = CW'(len);
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   task automatic pulse_run();
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
   endtask

   // Observes one burst: cycles until busy, handshake count, length, grant.
   task automatic measure_burst(output int lat, output int beats, output logic [LW-1:0] len,
                                output logic [N-1:0] rdy, output logic [AW-1:0] addr,
                                output logic stable);
      lat = 0; beats = 0; rdy = '0; stable = 1'b1;
      while (!busy && lat < 2000) begin
         @(negedge clk);
         lat++;
      end
      len = dma_len;
      addr = dma_addr;
      while (busy && beats < 2000) begin
         if (dma_len !== len || dma_addr !== addr) stable = 1'b0;
         rdy |= req_ready;
         if (dma_valid && dma_ready) beats++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      logic [DW-1:0] pat;
      rst = 1'b1; clear = 1'b0; run = 1'b0; cfg_valid = 1'b0; cfg_sel = '0;
      cfg_len = '0; req_valid = '1; dma_ready = 1'b1; dma_rdata = '0;
      req_addr = {ADDR1, ADDR0};
      @(negedge clk);
      vectors++;
      if ({busy, dma_valid, req_ready} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_outputs got busy/valid/ready=%b exp=0000", {busy, dma_valid, req_ready});
      end
      vectors++;
      if (dma_len !== '0 || dma_addr !== '0) begin
         miscompares++;
         $display("FAIL reset_len_addr got len=%0d addr=%h exp 0/0", dma_len, dma_addr);
      end
      req_valid = '0;
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         pat = {8{$urandom()}};
         dma_rdata = pat;
         #1;
         vectors++;
         if (req_rdata !== {pat, pat}) begin
            miscompares++;
            $display("FAIL rdata_broadcast got=%h exp=%h", req_rdata, {pat, pat});
         end
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         vectors++;
         if (busy !== 1'b0 || dma_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_arb cycle %0d got busy=%b valid=%b exp 0/0", i, busy, dma_valid);
         end
      end
   endtask

   task automatic test_clear();
      int lat, beats; logic [LW-1:0] len; logic [N-1:0] rdy; logic [AW-1:0] addr; logic st;
      do_reset();
      cfg_write(0, 5);
      clear = 1'b1; cfg_valid = 1'b1; cfg_sel = 1'b0; cfg_len = CW'(9);
      @(negedge clk);
      clear = 1'b0; cfg_valid = 1'b0;
      pulse_run();
      req_valid = 2'b01;
      measure_burst(lat, beats, len, rdy, addr, st);
      vectors++;
      if (len !== 8'd0 || beats !== 1) begin
         miscompares++;
         $display("FAIL clear_priority got len=%0d beats=%0d exp 0/1", len, beats);
      end
   endtask

   task automatic test_wrap();
      int lat, beats; logic [LW-1:0] len; logic [N-1:0] rdy; logic [AW-1:0] addr; logic st;
      do_reset();
      cfg_write(0, 3);
      pulse_run();
      req_valid = 2'b01;
      for (int b = 0; b < 2; b++) begin
         measure_burst(lat, beats, len, rdy, addr, st);
         vectors++;
         if (lat !== 1) begin
            miscompares++;
            $display("FAIL wrap_latency burst %0d got=%0d exp=1", b, lat);
         end
         vectors++;
         if (len !== 8'd3 || beats !== 4 || rdy !== 2'b01 || addr !== ADDR0 || !st) begin
            miscompares++;
            $display("FAIL wrap_burst %0d got len=%0d beats=%0d rdy=%b addr=%h st=%b exp 3/4/01/%h/1",
                     b, len, beats, rdy, addr, st, ADDR0);
         end
      end
   endtask

   task automatic test_long();
      int lat, beats, total; logic [LW-1:0] len; logic [N-1:0] rdy; logic [AW-1:0] addr; logic st;
      int exp_len [4] = '{255, 255, 87, 255};
      int exp_beats [4] = '{256, 256, 88, 256};
      do_reset();
      cfg_write(1, 599);
      pulse_run();
      req_valid = 2'b10;
      total = 0;
      for (int b = 0; b < 4; b++) begin
         measure_burst(lat, beats, len, rdy, addr, st);
         if (b < 3) total += beats;
         vectors++;
         if (int'(len) !== exp_len[b] || beats !== exp_beats[b] || rdy !== 2'b10 || !st) begin
            miscompares++;
            $display("FAIL long_burst %0d got len=%0d beats=%0d rdy=%b st=%b exp %0d/%0d/10/1",
                     b, len, beats, rdy, st, exp_len[b], exp_beats[b]);
         end
      end
      vectors++;
      if (total !== 600) begin
         miscompares++;
         $display("FAIL long_total got=%0d exp=600", total);
      end
   endtask

   task automatic test_alternate();
      int lat, beats; logic [LW-1:0] len; logic [N-1:0] rdy; logic [AW-1:0] addr; logic st;
      logic [N-1:0] exp_rdy; logic [AW-1:0] exp_addr;
      do_reset();
      cfg_write(0, 7);
      cfg_write(1, 7);
      pulse_run();
      req_valid = 2'b11;
      for (int b = 0; b < 4; b++) begin
         measure_burst(lat, beats, len, rdy, addr, st);
         exp_rdy  = (b % 2 == 0) ? 2'b01 : 2'b10;
         exp_addr = (b % 2 == 0) ? ADDR0 : ADDR1;
         vectors++;
         if (rdy !== exp_rdy || addr !== exp_addr || len !== 8'd7 || beats !== 8 || !st) begin
            miscompares++;
            $display("FAIL alternate_burst %0d got rdy=%b addr=%h len=%0d beats=%0d st=%b exp %b/%h/7/8/1",
                     b, rdy, addr, len, beats, st, exp_rdy, exp_addr);
         end
      end
   endtask

   task automatic test_stall();
      int lat, beats, t, hs; logic [LW-1:0] len; logic [N-1:0] rdy; logic [AW-1:0] addr; logic st;
      do_reset();
      cfg_write(0, 7);
      cfg_write(1, 7);
      pulse_run();
      req_valid = 2'b11;
      t = 0;
      while (!busy && t < 20) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      req_valid = 2'b10; dma_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         vectors++;
         if (busy !== 1'b1 || dma_valid !== 1'b0 || req_ready !== 2'b00 || dma_addr !== ADDR0) begin
            miscompares++;
            $display("FAIL stall_hold cycle %0d got busy=%b valid=%b rdy=%b addr=%h exp 1/0/00/%h",
                     i, busy, dma_valid, req_ready, dma_addr, ADDR0);
         end
      end
      req_valid = 2'b11; dma_ready = 1'b1;
      #1;
      hs = 0; t = 0;
      while (busy && t < 50) begin
         if (dma_valid && dma_ready && req_ready === 2'b01) hs++;
         @(negedge clk);
         t++;
      end
      vectors++;
      if (hs !== 5) begin
         miscompares++;
         $display("FAIL stall_resume got beats=%0d exp=5", hs);
      end
      measure_burst(lat, beats, len, rdy, addr, st);
      vectors++;
      if (rdy !== 2'b10 || beats !== 8) begin
         miscompares++;
         $display("FAIL stall_next got rdy=%b beats=%0d exp 10/8", rdy, beats);
      end
   endtask

   task automatic test_reset_mid();
      int lat, beats, t; logic [LW-1:0] len; logic [N-1:0] rdy; logic [AW-1:0] addr; logic st;
      do_reset();
      cfg_write(0, 7);
      pulse_run();
      req_valid = 2'b01;
      t = 0;
      while (!busy && t < 20) begin
         @(negedge clk);
         t++;
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      vectors++;
      if ({busy, dma_valid, req_ready} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_mid_outputs got busy/valid/ready=%b exp=0000", {busy, dma_valid, req_ready});
      end
      @(negedge clk);
      rst = 1'b0;
      req_valid = 2'b11;
      measure_burst(lat, beats, len, rdy, addr, st);
      vectors++;
      if (lat !== 1 || rdy !== 2'b01 || len !== 8'd0 || beats !== 1) begin
         miscompares++;
         $display("FAIL reset_mid_first got lat=%0d rdy=%b len=%0d beats=%0d exp 1/01/0/1",
                  lat, rdy, len, beats);
      end
   endtask

   task automatic test_run_mid();
      int lat, beats, t, hs; logic [LW-1:0] len; logic [N-1:0] rdy; logic [AW-1:0] addr; logic st;
      logic bad;
      do_reset();
      cfg_write(0, 7);
      cfg_write(1, 3);
      pulse_run();
      req_valid = 2'b11;
      t = 0;
      while (!busy && t < 20) begin
         @(negedge clk);
         t++;
      end
      hs = 0; t = 0; bad = 1'b0;
      while (busy && t < 50) begin
         if (dma_valid && dma_ready) hs++;
         if (dma_len !== 8'd7) bad = 1'b1;
         if (t == 3) begin cfg_valid = 1'b1; cfg_sel = 1'b1; cfg_len = CW'(15); end
         if (t == 4) begin cfg_valid = 1'b0; run = 1'b1; end
         if (t == 5) run = 1'b0;
         @(negedge clk);
         t++;
      end
      vectors++;
      if (hs !== 8 || bad) begin
         miscompares++;
         $display("FAIL run_mid_current got beats=%0d len_changed=%b exp 8/0", hs, bad);
      end
      measure_burst(lat, beats, len, rdy, addr, st);
      vectors++;
      if (rdy !== 2'b10 || len !== 8'd15 || beats !== 16) begin
         miscompares++;
         $display("FAIL run_mid_next got rdy=%b len=%0d beats=%0d exp 10/15/16", rdy, len, beats);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_clear();
      test_wrap();
      test_long();
      test_alternate();
      test_stall();
      test_reset_mid();
      test_run_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
